// File: rtl/wasm_int_alu_pkg.sv
// Shared constants and types for the WebAssembly integer ALU: opcodes, trap codes,
// value-type codes, ALU operation encoding and the opcode decoder.
package wasm_int_alu_pkg;

  localparam logic [7:0] OPC_I32_FIRST = 8'h6A;
  localparam logic [7:0] OPC_I32_LAST  = 8'h78;
  localparam logic [7:0] OPC_I64_FIRST = 8'h7C;
  localparam logic [7:0] OPC_I64_LAST  = 8'h8A;

  localparam logic [7:0] OPC_I32_ADD   = 8'h6A;
  localparam logic [7:0] OPC_I32_DIV_S = 8'h6D;
  localparam logic [7:0] OPC_I32_DIV_U = 8'h6E;
  localparam logic [7:0] OPC_I32_REM_S = 8'h6F;
  localparam logic [7:0] OPC_I32_REM_U = 8'h70;
  localparam logic [7:0] OPC_I32_SHR_S = 8'h75;
  localparam logic [7:0] OPC_I32_ROTL  = 8'h77;
  localparam logic [7:0] OPC_I64_ADD   = 8'h7C;
  localparam logic [7:0] OPC_I64_SUB   = 8'h7D;
  localparam logic [7:0] OPC_I64_MUL   = 8'h7E;
  localparam logic [7:0] OPC_I64_DIV_U = 8'h80;
  localparam logic [7:0] OPC_I64_REM_S = 8'h81;

  typedef enum logic [3:0] {
    TRAP_NONE         = 4'd0,
    TRAP_NO_64B       = 4'd1,
    TRAP_DIV_ZERO     = 4'd2,
    TRAP_INT_OVERFLOW = 4'd3,
    TRAP_UNKNOWN_OP   = 4'd4
  } trap_e;

  typedef enum logic [1:0] {
    TYPE_I32 = 2'd0,
    TYPE_I64 = 2'd1
  } val_type_e;

  // Operation index equals the opcode offset from the first opcode of its width.
  typedef enum logic [3:0] {
    ALU_ADD   = 4'd0,
    ALU_SUB   = 4'd1,
    ALU_MUL   = 4'd2,
    ALU_DIV_S = 4'd3,
    ALU_DIV_U = 4'd4,
    ALU_REM_S = 4'd5,
    ALU_REM_U = 4'd6,
    ALU_AND   = 4'd7,
    ALU_OR    = 4'd8,
    ALU_XOR   = 4'd9,
    ALU_SHL   = 4'd10,
    ALU_SHR_S = 4'd11,
    ALU_SHR_U = 4'd12,
    ALU_ROTL  = 4'd13,
    ALU_ROTR  = 4'd14
  } alu_op_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EXEC = 2'd1,
    ST_DIV  = 2'd2,
    ST_DONE = 2'd3
  } state_e;

  typedef struct packed {
    logic    known;
    logic    is64;
    alu_op_e op;
  } dec_t;

  function automatic dec_t decode_op(input logic [7:0] opc);
    dec_t       d;
    logic [7:0] idx;
    d.known = 1'b0;
    d.is64  = 1'b0;
    d.op    = ALU_ADD;
    idx     = 8'd0;
    if (opc >= OPC_I32_FIRST && opc <= OPC_I32_LAST) begin
      idx     = opc - OPC_I32_FIRST;
      d.known = 1'b1;
      d.op    = alu_op_e'(idx[3:0]);
    end else if (opc >= OPC_I64_FIRST && opc <= OPC_I64_LAST) begin
      idx     = opc - OPC_I64_FIRST;
      d.known = 1'b1;
      d.is64  = 1'b1;
      d.op    = alu_op_e'(idx[3:0]);
    end else begin
      d.known = 1'b0;
    end
    return d;
  endfunction

  function automatic logic is_div_op(input alu_op_e op);
    return (op == ALU_DIV_S) || (op == ALU_DIV_U) || (op == ALU_REM_S) || (op == ALU_REM_U);
  endfunction

endpackage

// File: rtl/wasm_int_div.sv
// Iterative restoring radix-2 unsigned divider, one quotient bit per cycle.
// narrow=1 divides the low W/2 bits in W/2 cycles by preloading the dividend into the upper half.
module wasm_int_div #(
  parameter int W = 64
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic         narrow,
  input  logic [W-1:0] dividend,
  input  logic [W-1:0] divisor,
  output logic         done,
  output logic [W-1:0] quotient,
  output logic [W-1:0] remainder
);

  localparam int CW = $clog2(W + 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(W);
  localparam logic [CW-1:0] HALF_CNT = CW'(W / 2);

  logic [W-1:0]  rem_r;
  logic [W-1:0]  quo_r;
  logic [W-1:0]  dsr_r;
  logic [CW-1:0] cnt_r;
  logic          done_r;
  logic [W:0]    shifted_s;
  logic [W:0]    diff_s;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    shifted_s = {rem_r, quo_r[W-1]};
    diff_s    = shifted_s - {1'b0, dsr_r};
  end

  // Load on start, then shift in one quotient bit per cycle until the counter drains.
  always_ff @(posedge clk) begin
    if (reset) begin
      rem_r  <= '0;
      quo_r  <= '0;
      dsr_r  <= '0;
      cnt_r  <= '0;
      done_r <= 1'b0;
    end else if (start) begin
      rem_r  <= '0;
      quo_r  <= narrow ? (dividend << (W / 2)) : dividend;
      dsr_r  <= divisor;
      cnt_r  <= narrow ? HALF_CNT : FULL_CNT;
      done_r <= 1'b0;
    end else if (cnt_r != '0) begin
      if (!diff_s[W]) begin
        rem_r <= diff_s[W-1:0];
        quo_r <= {quo_r[W-2:0], 1'b1};
      end else begin
        rem_r <= shifted_s[W-1:0];
        quo_r <= {quo_r[W-2:0], 1'b0};
      end
      cnt_r  <= cnt_r - CW'(1);
      done_r <= (cnt_r == CW'(1));
    end else begin
      done_r <= 1'b0;
    end
  end

  assign done      = done_r;
  assign quotient  = quo_r;
  assign remainder = rem_r;

endmodule

// File: rtl/wasm_int_alu.sv
// WebAssembly i32/i64 integer ALU: single-cycle arithmetic/logic/shift path plus an
// iterative divider for div/rem, with trap reporting and a start/busy/done handshake.
module wasm_int_alu
  import wasm_int_alu_pkg::*;
#(
  parameter bit USE_64B = 1'b1,
  parameter bit HAS_DIV = 1'b1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [7:0]  opcode,
  input  logic [63:0] lhs,
  input  logic [63:0] rhs,
  output logic        busy,
  output logic        done,
  output logic [63:0] result,
  output logic [1:0]  result_type,
  output logic [3:0]  trap
);

  localparam int DW = USE_64B ? 64 : 32;
  localparam bit WIDE_DP = (DW == 64);
  localparam logic [63:0] LO_MASK_64 = 64'h0000_0000_FFFF_FFFF;
  localparam logic [63:0] MIN64_64   = 64'h8000_0000_0000_0000;
  localparam logic [63:0] MIN32_64   = 64'h0000_0000_8000_0000;
  localparam logic [DW-1:0] LO_MASK  = LO_MASK_64[DW-1:0];
  localparam logic [DW-1:0] MIN_W64  = MIN64_64[DW-1:0];
  localparam logic [DW-1:0] MIN_W32  = MIN32_64[DW-1:0];

  // i32 values live in the low 32 bits of the shared datapath.
  function automatic logic [DW-1:0] fit(input logic [DW-1:0] v, input logic w64);
    if (w64) begin
      fit = v;
    end else begin
      fit = v & LO_MASK;
    end
  endfunction

  state_e    state_r, state_next_s;
  dec_t      dec_s;
  logic      req_w64_s, req_div_s, req_signed_s, go_div_s, narrow_s;
  logic      sign_a_s, sign_b_s;
  logic [DW-1:0] a_in_s, b_in_s, a_mag_s, b_mag_s, ones_s;
  trap_e     req_trap_s;
  val_type_e req_type_s;

  logic [DW-1:0] a_r, b_r;
  alu_op_e   op_r;
  logic      w64_r, neg_q_r, neg_rem_r;
  trap_e     trap_r;
  val_type_e type_r;

  logic [63:0] result_r;
  val_type_e   result_type_r;
  trap_e       trap_out_r;

  logic [5:0]    sh_s;
  logic [6:0]    wbits_s, back_s;
  logic [DW-1:0] sx_s, raw_s, alu_res_s, div_res_s, q_s, r_s;
  logic          div_start_s, div_done_s;
  logic [DW-1:0] div_quo_s, div_rem_s;

  // Classify the incoming request: width, operand masking, magnitudes and trap.
  always_comb begin
    dec_s        = decode_op(opcode);
    req_w64_s    = dec_s.known & dec_s.is64;
    a_in_s       = fit(lhs[DW-1:0], req_w64_s);
    b_in_s       = fit(rhs[DW-1:0], req_w64_s);
    ones_s       = fit('1, req_w64_s);
    req_div_s    = dec_s.known & is_div_op(dec_s.op);
    req_signed_s = (dec_s.op == ALU_DIV_S) || (dec_s.op == ALU_REM_S);
    sign_a_s     = req_w64_s ? a_in_s[DW-1] : a_in_s[31];
    sign_b_s     = req_w64_s ? b_in_s[DW-1] : b_in_s[31];
    a_mag_s      = (req_signed_s && sign_a_s) ? fit(-a_in_s, req_w64_s) : a_in_s;
    b_mag_s      = (req_signed_s && sign_b_s) ? fit(-b_in_s, req_w64_s) : b_in_s;
    narrow_s     = ~req_w64_s & WIDE_DP;
    if (!dec_s.known) begin
      req_trap_s = TRAP_UNKNOWN_OP;
    end else if (dec_s.is64 && !USE_64B) begin
      req_trap_s = TRAP_NO_64B;
    end else if (req_div_s && !HAS_DIV) begin
      req_trap_s = TRAP_UNKNOWN_OP;
    end else if (req_div_s && (b_in_s == '0)) begin
      req_trap_s = TRAP_DIV_ZERO;
    end else if ((dec_s.op == ALU_DIV_S) && (a_in_s == (req_w64_s ? MIN_W64 : MIN_W32))
                 && (b_in_s == ones_s)) begin
      req_trap_s = TRAP_INT_OVERFLOW;
    end else begin
      req_trap_s = TRAP_NONE;
    end
    if (dec_s.known && dec_s.is64) begin
      req_type_s = TYPE_I64;
    end else begin
      req_type_s = TYPE_I32;
    end
    go_div_s    = req_div_s && (req_trap_s == TRAP_NONE);
    div_start_s = (state_r == ST_IDLE) && start && go_div_s;
  end

  wasm_int_div #(.W(DW)) u_div (
    .clk       (clk),
    .reset     (reset),
    .start     (div_start_s),
    .narrow    (narrow_s),
    .dividend  (a_mag_s),
    .divisor   (b_mag_s),
    .done      (div_done_s),
    .quotient  (div_quo_s),
    .remainder (div_rem_s)
  );

  // Single-cycle operations on the latched operands.
  always_comb begin
    sh_s    = b_r[5:0] & (w64_r ? 6'd63 : 6'd31);
    wbits_s = w64_r ? 7'd64 : 7'd32;
    back_s  = wbits_s - {1'b0, sh_s};
    sx_s    = (!w64_r && a_r[31]) ? (a_r | ~LO_MASK) : a_r;
    case (op_r)
      ALU_ADD:   raw_s = a_r + b_r;
      ALU_SUB:   raw_s = a_r - b_r;
      ALU_MUL:   raw_s = a_r * b_r;
      ALU_AND:   raw_s = a_r & b_r;
      ALU_OR:    raw_s = a_r | b_r;
      ALU_XOR:   raw_s = a_r ^ b_r;
      ALU_SHL:   raw_s = a_r << sh_s;
      ALU_SHR_S: raw_s = $signed(sx_s) >>> sh_s;
      ALU_SHR_U: raw_s = a_r >> sh_s;
      ALU_ROTL:  raw_s = (a_r << sh_s) | (a_r >> back_s);
      ALU_ROTR:  raw_s = (a_r >> sh_s) | (a_r << back_s);
      default:   raw_s = '0;
    endcase
    alu_res_s = fit(raw_s, w64_r);
  end

  // Re-apply signs to the unsigned divider outputs.
  always_comb begin
    q_s = neg_q_r ? -div_quo_s : div_quo_s;
    r_s = neg_rem_r ? -div_rem_s : div_rem_s;
    if ((op_r == ALU_DIV_S) || (op_r == ALU_DIV_U)) begin
      div_res_s = fit(q_s, w64_r);
    end else begin
      div_res_s = fit(r_s, w64_r);
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r <= ST_IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // Next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      ST_IDLE: begin
        if (start) begin
          state_next_s = go_div_s ? ST_DIV : ST_EXEC;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_EXEC: state_next_s = ST_DONE;
      ST_DIV: begin
        if (div_done_s) begin
          state_next_s = ST_DONE;
        end else begin
          state_next_s = ST_DIV;
        end
      end
      ST_DONE: state_next_s = ST_IDLE;
      default: state_next_s = ST_IDLE;
    endcase
  end

  // Handshake outputs decoded from the state register.
  always_comb begin
    busy = 1'b0;
    done = 1'b0;
    case (state_r)
      ST_IDLE: begin
        busy = 1'b0;
        done = 1'b0;
      end
      ST_EXEC, ST_DIV: busy = 1'b1;
      ST_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: begin
        busy = 1'b0;
        done = 1'b0;
      end
    endcase
  end

  // Request latch; only an idle unit accepts a new request.
  always_ff @(posedge clk) begin
    if (reset) begin
      a_r       <= '0;
      b_r       <= '0;
      op_r      <= ALU_ADD;
      w64_r     <= 1'b0;
      neg_q_r   <= 1'b0;
      neg_rem_r <= 1'b0;
      trap_r    <= TRAP_NONE;
      type_r    <= TYPE_I32;
    end else if ((state_r == ST_IDLE) && start) begin
      a_r       <= a_in_s;
      b_r       <= b_in_s;
      op_r      <= dec_s.op;
      w64_r     <= req_w64_s;
      neg_q_r   <= req_signed_s & (sign_a_s ^ sign_b_s);
      neg_rem_r <= req_signed_s & sign_a_s;
      trap_r    <= req_trap_s;
      type_r    <= req_type_s;
    end
  end

  // Result registers update only when entering DONE and hold until the next completion.
  always_ff @(posedge clk) begin
    if (reset) begin
      result_r      <= '0;
      result_type_r <= TYPE_I32;
      trap_out_r    <= TRAP_NONE;
    end else if (state_next_s == ST_DONE) begin
      result_type_r <= type_r;
      trap_out_r    <= trap_r;
      if (trap_r != TRAP_NONE) begin
        result_r <= '0;
      end else if (state_r == ST_DIV) begin
        result_r <= 64'(div_res_s);
      end else begin
        result_r <= 64'(alu_res_s);
      end
    end
  end

  assign result      = result_r;
  assign result_type = result_type_r;
  assign trap        = trap_out_r;

endmodule
